mc_controller: RTL and testbench

- Multi-cycle main control FSM for the MIPS datapath.
- Replaces the single-cycle combinational decoder. Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states, waiting on memory with a ready handshake.
- Adds mult/div/mfhi/mflo support with parametrised busy latency, and a sticky illegal-instruction trap.
- Datapath control encodings are unchanged from the single-cycle controller.

---
 rtl/mc_controller.sv | 218 +++++++++++++++++++++
 tb/tb_mc_controller.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Purpose: multi-cycle main control FSM for the MIPS datapath (FETCH/DECODE/EXEC/MEM/WB/MDWAIT/TRAP).
// Latency: 2..5 cycles per instruction with mem_ready held high; mult/div take 3+MULT_LAT / 3+DIV_LAT.
// Backpressure: FETCH and MEM hold mem_read/mem_write until mem_ready; MDWAIT holds busy for the unit latency.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   op, func, zero        IR opcode/function fields, ALU equal flag (used in EXEC)
//   mem_ready             memory completion handshake
//   state                 current FSM state code
//   pc_write..mem_write   datapath strobes (combinational from state + inputs, forced low in reset)
//   reg_dst..alu_op       static decode of op/func, valid in every state
//   npc_sel               next-PC select, driven per state
//   md_start, md_op, busy mult/div launch pulse, operation select, wait indicator
//   instr_done, illegal   final-cycle pulse, sticky trap flag
module mc_controller #(
    parameter int ALUOP_W  = 8,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic [2:0]         state,
    output logic               pc_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic [1:0]         reg_dst,
    output logic               alu_src,
    output logic [1:0]         reg_src,
    output logic [1:0]         npc_sel,
    output logic [1:0]         ext_op,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               md_start,
    output logic               md_op,
    output logic               busy,
    output logic               instr_done,
    output logic               illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MDWAIT = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_ALU, C_LW, C_SW, C_BEQ, C_JAL, C_JR, C_MULT, C_DIV, C_ILL
    } cls_t;

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT - 1);

    state_t           state_q;
    cls_t             cls_q;
    cls_t             cls_now;
    logic [CNT_W-1:0] cnt_q;
    logic             illegal_q;

    assign state   = state_q;
    assign illegal = illegal_q;
    assign md_op   = (cls_q == C_DIV);

    // Instruction class straight from the IR; only sampled into cls_q in DECODE,
    // so later op/func changes cannot redirect an instruction in flight.
    always_comb begin
        cls_now = C_ILL;
        case (op)
            6'b000000: begin
                case (func)
                    6'b100000, 6'b100010, 6'b000000,
                    6'b010000, 6'b010010: cls_now = C_ALU;
                    6'b001000:            cls_now = C_JR;
                    6'b011000:            cls_now = C_MULT;
                    6'b011010:            cls_now = C_DIV;
                    default:              cls_now = C_ILL;
                endcase
            end
            6'b001101, 6'b001111: cls_now = C_ALU;
            6'b100011:            cls_now = C_LW;
            6'b101011:            cls_now = C_SW;
            6'b000100:            cls_now = C_BEQ;
            6'b000011:            cls_now = C_JAL;
            default:              cls_now = C_ILL;
        endcase
    end

    // Static datapath decode, same encodings as the single-cycle controller.
    always_comb begin
        reg_dst = 2'd0;
        alu_src = 1'b0;
        reg_src = 2'd0;
        ext_op  = 2'd0;
        alu_op  = ALUOP_W'(0);
        case (op)
            6'b000000: begin
                if (func == 6'b100010) alu_op = ALUOP_W'(1);
                if (func == 6'b000000) alu_op = ALUOP_W'(3);
                if (func == 6'b010000 || func == 6'b010010) reg_src = 2'd3;
            end
            6'b001101: begin reg_dst = 2'd1; alu_src = 1'b1; ext_op = 2'd0; alu_op = ALUOP_W'(2); end
            6'b001111: begin reg_dst = 2'd1; alu_src = 1'b1; ext_op = 2'd2; alu_op = ALUOP_W'(2); end
            6'b100011: begin reg_dst = 2'd1; alu_src = 1'b1; ext_op = 2'd1; reg_src = 2'd1; end
            6'b101011: begin alu_src = 1'b1; ext_op = 2'd1; end
            6'b000100: begin ext_op = 2'd1; alu_op = ALUOP_W'(4); end
            6'b000011: begin reg_dst = 2'd2; reg_src = 2'd2; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            cls_q     <= C_NOP;
        end else begin
            case (state_q)
                S_FETCH: if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    cls_q <= cls_now;
                    case (cls_now)
                        C_ILL: begin
                            illegal_q <= 1'b1;
                            state_q   <= S_TRAP;
                        end
                        C_JAL, C_JR: state_q <= S_FETCH;
                        default:     state_q <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (cls_q)
                        C_LW, C_SW: state_q <= S_MEM;
                        C_ALU:      state_q <= S_WB;
                        C_MULT: begin cnt_q <= MULT_LD; state_q <= S_MDWAIT; end
                        C_DIV:  begin cnt_q <= DIV_LD;  state_q <= S_MDWAIT; end
                        default:    state_q <= S_FETCH;
                    endcase
                end
                S_MDWAIT: begin
                    if (cnt_q == '0) state_q <= S_FETCH;
                    else             cnt_q   <= cnt_q - CNT_W'(1);
                end
                S_MEM: if (mem_ready) state_q <= (cls_q == C_LW) ? S_WB : S_FETCH;
                S_WB:   state_q <= S_FETCH;
                S_TRAP: state_q <= S_TRAP;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Strobes are combinational so FETCH/MEM can complete in the same cycle
    // mem_ready arrives; all are held low while reset is asserted.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        md_start   = 1'b0;
        busy       = 1'b0;
        instr_done = 1'b0;
        npc_sel    = 2'd0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_DECODE: begin
                    if (cls_now == C_JAL) begin
                        reg_write  = 1'b1;
                        pc_write   = 1'b1;
                        npc_sel    = 2'd2;
                        instr_done = 1'b1;
                    end else if (cls_now == C_JR) begin
                        pc_write   = 1'b1;
                        npc_sel    = 2'd3;
                        instr_done = 1'b1;
                    end
                end
                S_EXEC: begin
                    if (cls_q == C_BEQ) begin
                        pc_write   = zero;
                        npc_sel    = 2'd1;
                        instr_done = 1'b1;
                    end
                    md_start = (cls_q == C_MULT) || (cls_q == C_DIV);
                end
                S_MDWAIT: begin
                    busy       = 1'b1;
                    instr_done = (cnt_q == '0);
                end
                S_MEM: begin
                    mem_read   = (cls_q == C_LW);
                    mem_write  = (cls_q == C_SW);
                    instr_done = (cls_q == C_SW) && mem_ready;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Purpose: directed bench for mc_controller (instruction sequencing, handshakes, trap, reset).
// Latency: checks every cycle of each instruction against hand-computed state/strobe vectors.
// Backpressure: exercises mem_ready stalls in FETCH and MEM.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, func;
    logic       zero, mem_ready;
    logic [2:0] state;
    logic       pc_write, ir_write, reg_write, mem_read, mem_write;
    logic [1:0] reg_dst, reg_src, npc_sel, ext_op;
    logic       alu_src;
    logic [7:0] alu_op;
    logic       md_start, md_op, busy, instr_done, illegal;

    int tests = 0;
    int fails = 0;

    // {pc_write, ir_write, reg_write, mem_read, mem_write, md_start, busy, instr_done}
    logic [7:0] strb;
    assign strb = {pc_write, ir_write, reg_write, mem_read, mem_write, md_start, busy, instr_done};

    localparam logic [7:0] B_FETCH = 8'b1101_0000;
    localparam logic [7:0] B_RD    = 8'b0001_0000;
    localparam logic [7:0] B_NONE  = 8'b0000_0000;
    localparam logic [7:0] B_WB    = 8'b0010_0001;
    localparam logic [7:0] B_BUSY  = 8'b0000_0010;

    always #5 clk = ~clk;

    mc_controller #(.ALUOP_W(8), .MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
        .state(state), .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_dst(reg_dst), .alu_src(alu_src),
        .reg_src(reg_src), .npc_sel(npc_sel), .ext_op(ext_op), .alu_op(alu_op),
        .md_start(md_start), .md_op(md_op), .busy(busy), .instr_done(instr_done),
        .illegal(illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge; outputs are checked 2 units later.
    task automatic cyc(input string tag, input logic [2:0] es, input logic [7:0] eb);
        #2;
        chk({tag, "/state"}, 32'(state), 32'(es));
        chk({tag, "/strb"}, 32'(strb), 32'(eb));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; op = 6'd0; func = 6'b100000; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        // In reset with state FETCH and mem_ready high, strobes must still be low.
        #2;
        chk("rst/illegal", 32'(illegal), 32'd0);
        cyc("rst", 3'd0, B_NONE);
        reset = 1'b0;

        // add
        cyc("add/f", 3'd0, B_FETCH);
        cyc("add/d", 3'd1, B_NONE);
        cyc("add/e", 3'd2, B_NONE);
        #2; chk("add/reg_dst", 32'(reg_dst), 32'd0);
        cyc("add/wb", 3'd4, B_WB);

        // lw with FETCH and MEM stalls
        op = 6'b100011; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw/fstall", 3'd0, B_RD);
        mem_ready = 1'b1;
        cyc("lw/f", 3'd0, B_FETCH);
        cyc("lw/d", 3'd1, B_NONE);
        cyc("lw/e", 3'd2, B_NONE);
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) cyc("lw/mstall", 3'd3, B_RD);
        mem_ready = 1'b1;
        cyc("lw/m", 3'd3, B_RD);
        #2; chk("lw/reg_src", 32'(reg_src), 32'd1);
        cyc("lw/wb", 3'd4, B_WB);

        // sw; op changes in EXEC must not redirect the latched class
        op = 6'b101011;
        cyc("sw/f", 3'd0, B_FETCH);
        cyc("sw/d", 3'd1, B_NONE);
        op = 6'b000000; func = 6'b100000;
        cyc("sw/e", 3'd2, B_NONE);
        cyc("sw/m", 3'd3, 8'b0000_1001);

        // beq taken, then not taken
        op = 6'b000100; zero = 1'b1;
        cyc("beq1/f", 3'd0, B_FETCH);
        cyc("beq1/d", 3'd1, B_NONE);
        #2; chk("beq1/npc_sel", 32'(npc_sel), 32'd1);
        cyc("beq1/e", 3'd2, 8'b1000_0001);
        zero = 1'b0;
        cyc("beq2/f", 3'd0, B_FETCH);
        cyc("beq2/d", 3'd1, B_NONE);
        cyc("beq2/e", 3'd2, 8'b0000_0001);

        // jal, jr
        op = 6'b000011;
        cyc("jal/f", 3'd0, B_FETCH);
        #2;
        chk("jal/npc_sel", 32'(npc_sel), 32'd2);
        chk("jal/reg_dst", 32'(reg_dst), 32'd2);
        chk("jal/reg_src", 32'(reg_src), 32'd2);
        cyc("jal/d", 3'd1, 8'b1010_0001);
        op = 6'b000000; func = 6'b001000;
        cyc("jr/f", 3'd0, B_FETCH);
        #2; chk("jr/npc_sel", 32'(npc_sel), 32'd3);
        cyc("jr/d", 3'd1, 8'b1000_0001);

        // mult: 5 busy cycles, instr_done on the last
        func = 6'b011000;
        cyc("mult/f", 3'd0, B_FETCH);
        cyc("mult/d", 3'd1, B_NONE);
        #2; chk("mult/md_op", 32'(md_op), 32'd0);
        cyc("mult/e", 3'd2, 8'b0000_0100);
        for (int i = 0; i < 4; i++) cyc("mult/w", 3'd5, B_BUSY);
        cyc("mult/wlast", 3'd5, 8'b0000_0011);

        // div: 10 busy cycles
        func = 6'b011010;
        cyc("div/f", 3'd0, B_FETCH);
        cyc("div/d", 3'd1, B_NONE);
        #2; chk("div/md_op", 32'(md_op), 32'd1);
        cyc("div/e", 3'd2, 8'b0000_0100);
        for (int i = 0; i < 9; i++) cyc("div/w", 3'd5, B_BUSY);
        cyc("div/wlast", 3'd5, 8'b0000_0011);

        // mfhi static decode
        func = 6'b010000;
        #2; chk("mfhi/reg_src", 32'(reg_src), 32'd3);
        cyc("back/f", 3'd0, B_FETCH);
        cyc("mfhi/d", 3'd1, B_NONE);
        cyc("mfhi/e", 3'd2, B_NONE);
        cyc("mfhi/wb", 3'd4, B_WB);

        // illegal opcode -> sticky TRAP
        op = 6'b111111;
        cyc("ill/f", 3'd0, B_FETCH);
        #2; chk("ill/dec_flag", 32'(illegal), 32'd0);
        cyc("ill/d", 3'd1, B_NONE);
        for (int i = 0; i < 20; i++) begin
            chk("ill/flag", 32'(illegal), 32'd1);
            cyc("ill/trap", 3'd6, B_NONE);
        end
        reset = 1'b1;
        cyc("ill/rst", 3'd6, B_NONE);
        reset = 1'b0; op = 6'd0; func = 6'b011000;
        #2; chk("ill/cleared", 32'(illegal), 32'd0);
        cyc("mrst/f", 3'd0, B_FETCH);

        // reset on the 2nd MDWAIT cycle aborts mult
        cyc("mrst/d", 3'd1, B_NONE);
        cyc("mrst/e", 3'd2, 8'b0000_0100);
        cyc("mrst/w1", 3'd5, B_BUSY);
        reset = 1'b1;
        cyc("mrst/w2", 3'd5, B_NONE);
        reset = 1'b0; mem_ready = 1'b0;
        cyc("mrst/after", 3'd0, B_RD);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
